// File: rtl/mem_req_pkg.sv
// Shared state encoding, request record and defaults for the memory request master.
package mem_req_pkg;

    localparam int ADDR_W      = 16;
    localparam int WORD_W      = 16;
    localparam int DEF_TIMEOUT = 64;
    localparam int TMO_W       = 16;

    typedef logic [1:0] state_t;

    // 2'd3 is unused and recovers to IDLE
    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t RESP  = 2'd2;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Loadable down-counter that flags when the stall budget of the current request is used up.
module mem_timeout_cnt #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mem_req_master.sv
// Single-outstanding load/store initiator for the stalling memory: latches a request,
// holds it across stalls, and returns one registered response pulse per request.
module mem_req_master
    import mem_req_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_wr,
    input  logic [15:0]      req_addr,
    input  logic [15:0]      req_wdata,
    output logic             req_ready,
    output logic             resp_valid,
    output logic [15:0]      resp_rdata,
    output logic             resp_err,
    output logic             resp_timeout,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_datain,
    input  logic [15:0]      mem_dataout,
    input  logic             mem_done,
    input  logic             mem_stall,
    input  logic             mem_err
);

    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    state_t            state_q, state_d;
    mem_req_t          req_q, req_d;
    logic              resp_valid_q, resp_valid_d;
    logic [15:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              resp_tmo_q, resp_tmo_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              tmo_load, tmo_dec, tmo_expired;

    // mem_done alone decides completion; mem_stall carries no extra information here
    logic unused_mem_stall;
    assign unused_mem_stall = mem_stall;

    mem_timeout_cnt #(
        .W (TMO_W)
    ) u_tmo (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .load_i     (tmo_load),
        .load_val_i (TMO_LOAD),
        .dec_i      (tmo_dec),
        .expired_o  (tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        resp_tmo_d   = 1'b0;
        stall_d      = stall_q;
        tmo_load     = 1'b0;
        tmo_dec      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
                    if (req_addr[0]) begin
                        // misaligned: answer directly, the memory is never touched
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d  = ISSUE;
                        tmo_load = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (mem_done) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = mem_err;
                    resp_rdata_d = (req_q.wr || mem_err) ? 16'h0000 : mem_dataout;
                end else begin
                    stall_d = sat_inc(stall_q);
                    if (tmo_expired) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_tmo_d   = 1'b1;
                    end else begin
                        tmo_dec = 1'b1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            resp_tmo_q   <= 1'b0;
            stall_q      <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            resp_tmo_q   <= resp_tmo_d;
            stall_q      <= stall_d;
        end
    end

    // strobes decode from state so an asynchronous reset drops them at once
    assign mem_rd       = (state_q == ISSUE) && !req_q.wr;
    assign mem_wr       = (state_q == ISSUE) &&  req_q.wr;
    assign mem_addr     = req_q.addr;
    assign mem_datain   = req_q.wdata;

    assign req_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign resp_timeout = resp_tmo_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a small stalling memory model (TIMEOUT=8, CNT_W=8).
module tb_mem_req_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err, resp_timeout, busy;
    logic [15:0] resp_rdata;
    logic [7:0]  stall_cycles;
    logic        mem_rd, mem_wr;
    logic [15:0] mem_addr, mem_datain, mem_dataout;
    logic        mem_done, mem_stall, mem_err;

    mem_req_master #(.TIMEOUT(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_timeout(resp_timeout), .busy(busy),
        .stall_cycles(stall_cycles),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_datain(mem_datain),
        .mem_dataout(mem_dataout), .mem_done(mem_done), .mem_stall(mem_stall), .mem_err(mem_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory model: completes after stall_cfg stall cycles unless force_stall is set
    int          stall_cfg = 0;
    bit          force_stall = 1'b0;
    bit          err_cfg = 1'b0;
    int          act_cycles = 0;
    logic [15:0] mem_arr [256];
    bit          written [256];
    logic        mem_active;
    logic [7:0]  idx;

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hBEEF : (a ^ 16'hA5A5);
    endfunction

    assign mem_active  = mem_rd | mem_wr;
    assign idx         = mem_addr[8:1];
    assign mem_done    = mem_active && !force_stall && (act_cycles >= stall_cfg);
    assign mem_stall   = mem_active && !mem_done;
    assign mem_err     = mem_done && err_cfg;
    assign mem_dataout = !mem_done ? 16'h0000 : (written[idx] ? mem_arr[idx] : init_word(mem_addr));

    always @(posedge clk) begin
        if (mem_active) begin
            if (!mem_done) act_cycles <= act_cycles + 1;
        end else begin
            act_cycles <= 0;
        end
        if (mem_done && mem_wr) begin
            mem_arr[idx] <= mem_datain;
            written[idx] <= 1'b1;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          stalls;     // -1 = memory never completes
        logic        merr;
        logic [15:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        int          exp_lat;    // cycles from accept edge to resp_valid
        int          exp_strb;   // cycles with a strobe asserted
        int          exp_stall;  // stall_cycles increase
    } vec_t;

    vec_t vecs[11];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, strobes, guard, accepts, resps, bad_ready, both_cnt;
        logic stable, both;
        logic [7:0] st0;

        vecs[0]  = '{1'b0, 16'h0010, 16'h0000,  0, 1'b0, 16'hBEEF, 1'b0, 1'b0, 2, 1, 0};
        vecs[1]  = '{1'b1, 16'h0020, 16'h1234,  3, 1'b0, 16'h0000, 1'b0, 1'b0, 5, 4, 3};
        vecs[2]  = '{1'b0, 16'h0020, 16'h0000,  0, 1'b0, 16'h1234, 1'b0, 1'b0, 2, 1, 0};
        vecs[3]  = '{1'b0, 16'h0031, 16'h0000,  0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 0, 0};
        vecs[4]  = '{1'b1, 16'h0041, 16'hDEAD,  0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 0, 0};
        vecs[5]  = '{1'b0, 16'h0040, 16'h0000,  1, 1'b0, 16'hA5E5, 1'b0, 1'b0, 3, 2, 1};
        vecs[6]  = '{1'b0, 16'h0050, 16'h0000,  7, 1'b0, 16'hA5F5, 1'b0, 1'b0, 9, 8, 7};
        vecs[7]  = '{1'b0, 16'h0060, 16'h0000, -1, 1'b0, 16'h0000, 1'b1, 1'b1, 9, 8, 8};
        vecs[8]  = '{1'b1, 16'h0070, 16'h5555,  2, 1'b0, 16'h0000, 1'b0, 1'b0, 4, 3, 2};
        vecs[9]  = '{1'b0, 16'h0070, 16'h0000,  0, 1'b0, 16'h5555, 1'b0, 1'b0, 2, 1, 0};
        vecs[10] = '{1'b0, 16'h0080, 16'h0000,  0, 1'b1, 16'h0000, 1'b1, 1'b0, 2, 1, 0};

        rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        step(); step();
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_strobes", {mem_rd, mem_wr}, 0);
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_mem_addr", mem_addr, 0);
        #3 rst_n = 1'b1;
        step();

        // table-driven transactions
        for (int i = 0; i < 11; i++) begin
            stall_cfg   = (vecs[i].stalls < 0) ? 0 : vecs[i].stalls;
            force_stall = (vecs[i].stalls < 0);
            err_cfg     = vecs[i].merr;
            req_wr = vecs[i].wr; req_addr = vecs[i].addr; req_wdata = vecs[i].wdata;
            req_valid = 1'b1;
            guard = 0;
            while (!req_ready && guard < 20) begin step(); guard++; end
            check($sformatf("v%0d_ready", i), req_ready, 1);
            st0 = stall_cycles;
            step();
            req_valid = 1'b0;
            n = 1; strobes = 0; stable = 1'b1; both = 1'b0;
            while (!resp_valid && n < 40) begin
                if (mem_active) begin
                    strobes++;
                    if (mem_addr !== vecs[i].addr || mem_wr !== vecs[i].wr ||
                        (vecs[i].wr && mem_datain !== vecs[i].wdata)) stable = 1'b0;
                end
                if (mem_rd && mem_wr) both = 1'b1;
                step();
                n++;
            end
            check($sformatf("v%0d_latency", i), n, vecs[i].exp_lat);
            check($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), resp_err, vecs[i].exp_err);
            check($sformatf("v%0d_timeout", i), resp_timeout, vecs[i].exp_tmo);
            check($sformatf("v%0d_strobe_cycles", i), strobes, vecs[i].exp_strb);
            check($sformatf("v%0d_req_stable", i), stable, 1);
            check($sformatf("v%0d_both_strobes", i), both, 0);
            check($sformatf("v%0d_strobe_in_resp", i), mem_active, 0);
            check($sformatf("v%0d_ready_in_resp", i), req_ready, 0);
            check($sformatf("v%0d_stall_delta", i), 8'(stall_cycles - st0), vecs[i].exp_stall);
            step();
            check($sformatf("v%0d_single_pulse", i), resp_valid, 0);
        end
        force_stall = 1'b0; err_cfg = 1'b0; stall_cfg = 0;

        // asynchronous reset in the 2nd stall cycle of a load
        force_stall = 1'b1;
        req_wr = 1'b0; req_addr = 16'h0090; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        check("ar_mem_rd_before", mem_rd, 1);
        check("ar_stall_before", stall_cycles, 8'(st0 + 8'd1));
        #2 rst_n = 1'b0;
        #1;
        check("ar_mem_rd_async", mem_rd, 0);
        check("ar_busy_async", busy, 0);
        check("ar_stall_async", stall_cycles, 0);
        force_stall = 1'b0;
        step();
        #3 rst_n = 1'b1;
        resps = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            if (resp_valid) resps++;
        end
        check("ar_no_resp", resps, 0);
        check("ar_ready_after", req_ready, 1);
        check("ar_stall_after", stall_cycles, 0);

        // req_valid held high with random stalls
        accepts = 0; resps = 0; bad_ready = 0; both_cnt = 0;
        stall_cfg = 1;
        req_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (req_ready && req_valid) accepts++;
            if (resp_valid) begin
                resps++;
                stall_cfg = $urandom_range(0, 3);
            end
            if (req_ready == busy) bad_ready++;
            if (mem_rd && mem_wr) both_cnt++;
            req_wr   = 1'($urandom_range(0, 1));
            req_addr = 16'($urandom_range(0, 65535)) & 16'hFFFE;
            req_wdata = 16'($urandom_range(0, 65535));
            step();
        end
        req_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (resp_valid) resps++;
            if (mem_rd && mem_wr) both_cnt++;
            step();
        end
        check("tp_resp_per_accept", resps, accepts);
        check("tp_min_accepts", (accepts >= 30), 1);
        check("tp_ready_vs_busy", bad_ready, 0);
        check("tp_both_strobes", both_cnt, 0);

        // stall counter saturation through repeated timeouts
        force_stall = 1'b1;
        req_wr = 1'b0; req_addr = 16'h0100; req_valid = 1'b1;
        repeat (400) step();
        req_valid = 1'b0;
        guard = 0;
        while (busy && guard < 20) begin step(); guard++; end
        check("sat_idle", busy, 0);
        check("sat_stall_cycles", stall_cycles, 8'hFF);
        force_stall = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
